// File: rtl/write_mem_v2_pkg.sv
// Shared types and constants for the sample-to-memory writer.
package write_mem_v2_pkg;

  // Controller states
  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_RUN  = 2'd1,
    ST_ACK  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Window modes selected by MODE_REG
  localparam logic MODE_ONESHOT = 1'b0;
  localparam logic MODE_CIRC    = 1'b1;

endpackage

// File: rtl/write_mem_v2_if.sv
// Producer handshake plus memory write port of the sample writer.
interface write_mem_v2_if #(
  parameter int N = 8,
  parameter int B = 16
);
  logic [B-1:0] din;
  logic         write;
  logic         write_ack;
  logic         mem_we;
  logic [N-1:0] mem_addr;
  logic [B-1:0] mem_di;

  // Producer / memory-observer side
  modport master (
    output din, write,
    input  write_ack, mem_we, mem_addr, mem_di
  );

  // Writer side
  modport slave (
    input  din, write,
    output write_ack, mem_we, mem_addr, mem_di
  );
endinterface

// File: rtl/wm_addr_gen.sv
// Window address generator: latched base plus an offset that wraps after
// nsamp stores; the sum wraps naturally at 2^N.
module wm_addr_gen #(
  parameter int N = 8
) (
  input  logic         aclk,
  input  logic         aresetn,
  input  logic         load,
  input  logic [N-1:0] base,
  input  logic [N-1:0] nsamp,
  input  logic         step,
  output logic [N-1:0] addr,
  output logic         last
);
  logic [N-1:0] base_r;
  logic [N-1:0] nsamp_r;
  logic [N-1:0] offset_r;

  assign addr = base_r + offset_r;
  assign last = (offset_r == (nsamp_r - N'(1)));

  // Latch the window on start and advance the offset after each store
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      base_r   <= {N{1'b0}};
      nsamp_r  <= {N{1'b0}};
      offset_r <= {N{1'b0}};
    end else if (load) begin
      base_r   <= base;
      nsamp_r  <= nsamp;
      offset_r <= {N{1'b0}};
    end else if (step) begin
      offset_r <= last ? {N{1'b0}} : (offset_r + N'(1));
    end else begin
      offset_r <= offset_r;
    end
  end
endmodule

// File: rtl/write_mem_v2.sv
// Accepts samples over a 4-phase handshake and writes every (DECIM+1)-th
// one into a memory window, one-shot or circular.
module write_mem_v2
  import write_mem_v2_pkg::*;
#(
  parameter int N = 8,
  parameter int B = 16,
  parameter int D = 8
) (
  input  logic          aclk,
  input  logic          aresetn,
  write_mem_v2_if.slave bus,
  input  logic          START_REG,
  input  logic [N-1:0]  ADDR_REG,
  input  logic [N-1:0]  NSAMP_REG,
  input  logic          MODE_REG,
  input  logic [D-1:0]  DECIM_REG,
  output logic          busy,
  output logic          done,
  output logic [N-1:0]  wcnt
);
  state_t       state_r, state_nx;
  logic         mode_r;
  logic [D-1:0] decim_r;
  logic [D-1:0] dcnt_r;
  logic         full_r;
  logic         start_run_s, accept_s, store_s, addr_last_s;
  logic [N-1:0] addr_s;
  logic         write_ack_r, mem_we_r, busy_r, done_r;
  logic [N-1:0] mem_addr_r, wcnt_r;
  logic [B-1:0] mem_di_r;

  assign start_run_s = (state_r == ST_INIT) && START_REG && (NSAMP_REG != {N{1'b0}});
  assign accept_s    = (state_r == ST_RUN) && START_REG && bus.write;
  assign store_s     = accept_s && (dcnt_r == {D{1'b0}});

  assign bus.write_ack = write_ack_r;
  assign bus.mem_we    = mem_we_r;
  assign bus.mem_addr  = mem_addr_r;
  assign bus.mem_di    = mem_di_r;
  assign busy          = busy_r;
  assign done          = done_r;
  assign wcnt          = wcnt_r;

  wm_addr_gen #(.N(N)) u_addr_gen (
    .aclk    (aclk),
    .aresetn (aresetn),
    .load    (start_run_s),
    .base    (ADDR_REG),
    .nsamp   (NSAMP_REG),
    .step    (store_s),
    .addr    (addr_s),
    .last    (addr_last_s)
  );

  // Controller state register
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state_r <= ST_INIT;
    else          state_r <= state_nx;
  end

  // Next-state logic; a one-shot run ends once the decimation period holding
  // the final stored sample has been fully accepted (counter back at zero)
  always_comb begin
    state_nx = state_r;
    case (state_r)
      ST_INIT: begin
        if (START_REG) state_nx = (NSAMP_REG == {N{1'b0}}) ? ST_DONE : ST_RUN;
        else           state_nx = ST_INIT;
      end
      ST_RUN: begin
        if (!START_REG)     state_nx = ST_INIT;
        else if (bus.write) state_nx = ST_ACK;
        else                state_nx = ST_RUN;
      end
      ST_ACK: begin
        if (bus.write)
          state_nx = ST_ACK;
        else if ((mode_r == MODE_ONESHOT) && full_r && (dcnt_r == {D{1'b0}}))
          state_nx = ST_DONE;
        else if (!START_REG)
          state_nx = ST_INIT;
        else
          state_nx = ST_RUN;
      end
      ST_DONE: begin
        if (START_REG) state_nx = ST_DONE;
        else           state_nx = ST_INIT;
      end
      default: state_nx = ST_INIT;
    endcase
  end

  // Run configuration, decimation counter and window-complete flag
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      mode_r  <= MODE_ONESHOT;
      decim_r <= {D{1'b0}};
      dcnt_r  <= {D{1'b0}};
      full_r  <= 1'b0;
    end else if (start_run_s) begin
      mode_r  <= MODE_REG;
      decim_r <= DECIM_REG;
      dcnt_r  <= {D{1'b0}};
      full_r  <= 1'b0;
    end else begin
      if (accept_s) dcnt_r <= (dcnt_r == decim_r) ? {D{1'b0}} : (dcnt_r + D'(1));
      else          dcnt_r <= dcnt_r;
      if (store_s && addr_last_s) full_r <= 1'b1;
      else                        full_r <= full_r;
    end
  end

  // Registered handshake, memory port and status outputs
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      write_ack_r <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= {N{1'b0}};
      mem_di_r    <= {B{1'b0}};
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      wcnt_r      <= {N{1'b0}};
    end else begin
      write_ack_r <= (state_nx == ST_ACK);
      mem_we_r    <= store_s;
      busy_r      <= (state_nx == ST_RUN) || (state_nx == ST_ACK);
      done_r      <= (state_nx == ST_DONE);
      if (store_s) begin
        mem_addr_r <= addr_s;
        mem_di_r   <= bus.din;
      end else begin
        mem_addr_r <= mem_addr_r;
        mem_di_r   <= mem_di_r;
      end
      if (start_run_s)  wcnt_r <= {N{1'b0}};
      else if (store_s) wcnt_r <= wcnt_r + N'(1);
      else              wcnt_r <= wcnt_r;
    end
  end
endmodule

// File: tb/tb_write_mem_v2.sv
// Scoreboard bench for write_mem_v2: expected stores are queued as samples
// are driven and compared whenever the writer pulses mem_we.
module tb_write_mem_v2;
  logic       aclk = 1'b0;
  logic       aresetn = 1'b0;
  logic       START_REG = 1'b0;
  logic [7:0] ADDR_REG = 8'd0;
  logic [7:0] NSAMP_REG = 8'd0;
  logic       MODE_REG = 1'b0;
  logic [7:0] DECIM_REG = 8'd0;
  logic       busy, done;
  logic [7:0] wcnt;

  typedef struct packed {
    logic [7:0]  addr;
    logic [15:0] data;
  } exp_t;
  exp_t sb[$];
  int checks = 0;
  int failures = 0;

  always #5 aclk = ~aclk;

  write_mem_v2_if #(.N(8), .B(16)) bus ();

  write_mem_v2 #(.N(8), .B(16), .D(8)) dut (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .bus       (bus),
    .START_REG (START_REG),
    .ADDR_REG  (ADDR_REG),
    .NSAMP_REG (NSAMP_REG),
    .MODE_REG  (MODE_REG),
    .DECIM_REG (DECIM_REG),
    .busy      (busy),
    .done      (done),
    .wcnt      (wcnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic expect_store(input logic [7:0] a, input logic [15:0] d);
    exp_t e;
    e.addr = a;
    e.data = d;
    sb.push_back(e);
  endtask

  // Compare every memory write against the head of the scoreboard
  always @(negedge aclk) begin
    exp_t e;
    if (bus.mem_we === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_we", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("store_addr", {24'd0, bus.mem_addr}, {24'd0, e.addr});
        chk("store_data", {16'd0, bus.mem_di}, {16'd0, e.data});
      end
    end
  end

  task automatic wait_ack(output logic got);
    got = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge aclk);
      if (bus.write_ack === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  // One full 4-phase handshake; write is held two extra cycles after ack
  task automatic hs(input logic [15:0] d, input logic exp_ack);
    logic got;
    logic low;
    @(negedge aclk);
    bus.din   = d;
    bus.write = 1'b1;
    wait_ack(got);
    chk("ack", {31'd0, got}, {31'd0, exp_ack});
    if (got) begin
      repeat (2) @(negedge aclk);
      chk("ack_hold", {31'd0, bus.write_ack}, 32'd1);
    end
    bus.write = 1'b0;
    bus.din   = 16'hdead;
    if (got) begin
      low = 1'b0;
      for (int i = 0; i < 8; i++) begin
        @(negedge aclk);
        if (bus.write_ack === 1'b0) begin
          low = 1'b1;
          break;
        end
      end
      chk("ack_drop", {31'd0, low}, 32'd1);
    end
  endtask

  task automatic start_run(input logic [7:0] a, input logic [7:0] n,
                           input logic m, input logic [7:0] dec);
    @(negedge aclk);
    ADDR_REG  = a;
    NSAMP_REG = n;
    MODE_REG  = m;
    DECIM_REG = dec;
    START_REG = 1'b1;
    @(negedge aclk);
    ADDR_REG  = 8'hff;
    NSAMP_REG = 8'd1;
    MODE_REG  = ~m;
    DECIM_REG = 8'd5;
    chk("busy_start", {31'd0, busy}, 32'd1);
  endtask

  task automatic stop_run;
    @(negedge aclk);
    START_REG = 1'b0;
    repeat (2) @(negedge aclk);
    chk("idle_busy", {31'd0, busy}, 32'd0);
    chk("idle_done", {31'd0, done}, 32'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ack"}, {31'd0, bus.write_ack}, 32'd0);
    chk({tag, "_we"}, {31'd0, bus.mem_we}, 32'd0);
    chk({tag, "_addr"}, {24'd0, bus.mem_addr}, 32'd0);
    chk({tag, "_di"}, {16'd0, bus.mem_di}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_done"}, {31'd0, done}, 32'd0);
    chk({tag, "_wcnt"}, {24'd0, wcnt}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic got;
    bus.din   = 16'd0;
    bus.write = 1'b0;
    repeat (3) @(negedge aclk);
    chk_all_zero("reset");
    aresetn = 1'b1;

    // One-shot, 10 stores from address 0; the 11th and 12th writes stall
    start_run(8'd0, 8'd10, 1'b0, 8'd0);
    for (int i = 0; i < 12; i++) begin
      if (i < 10) expect_store(8'(i), 16'(16'h1000 + i));
      hs(16'(16'h1000 + i), (i < 10));
    end
    chk("t1_done", {31'd0, done}, 32'd1);
    chk("t1_busy", {31'd0, busy}, 32'd0);
    chk("t1_wcnt", {24'd0, wcnt}, 32'd10);
    chk("t1_sb", sb.size(), 32'd0);
    stop_run();

    // Window straddling the top of memory
    start_run(8'd250, 8'd10, 1'b0, 8'd0);
    for (int i = 0; i < 10; i++) begin
      expect_store(8'(250 + i), 16'(16'h2000 + i));
      hs(16'(16'h2000 + i), 1'b1);
    end
    chk("t2_done", {31'd0, done}, 32'd1);
    chk("t2_wcnt", {24'd0, wcnt}, 32'd10);
    stop_run();

    // Circular window of 5 at address 7
    start_run(8'd7, 8'd5, 1'b1, 8'd0);
    for (int i = 0; i < 12; i++) begin
      expect_store(8'(7 + (i % 5)), 16'(16'h3000 + i));
      hs(16'(16'h3000 + i), 1'b1);
    end
    chk("t3_done", {31'd0, done}, 32'd0);
    chk("t3_wcnt", {24'd0, wcnt}, 32'd12);
    stop_run();

    // Decimation by 3: samples 1,4,7,10 stored, all 12 acknowledged
    start_run(8'd20, 8'd4, 1'b0, 8'd2);
    for (int i = 0; i < 12; i++) begin
      if ((i % 3) == 0) expect_store(8'(20 + i / 3), 16'(16'h4000 + i));
      hs(16'(16'h4000 + i), 1'b1);
    end
    chk("t4_done", {31'd0, done}, 32'd1);
    chk("t4_wcnt", {24'd0, wcnt}, 32'd4);
    stop_run();

    // START dropped mid-handshake, then restart at address 7
    start_run(8'd30, 8'd10, 1'b0, 8'd0);
    expect_store(8'd30, 16'h5000);
    hs(16'h5000, 1'b1);
    expect_store(8'd31, 16'h5001);
    @(negedge aclk);
    bus.din   = 16'h5001;
    bus.write = 1'b1;
    wait_ack(got);
    chk("t5_ack", {31'd0, got}, 32'd1);
    START_REG = 1'b0;
    bus.din   = 16'hbeef;
    repeat (2) @(negedge aclk);
    chk("t5_ack_hold", {31'd0, bus.write_ack}, 32'd1);
    bus.write = 1'b0;
    @(negedge aclk);
    chk("t5_ack_low", {31'd0, bus.write_ack}, 32'd0);
    chk("t5_busy", {31'd0, busy}, 32'd0);
    start_run(8'd7, 8'd5, 1'b0, 8'd0);
    expect_store(8'd7, 16'h5100);
    hs(16'h5100, 1'b1);
    chk("t5_wcnt", {24'd0, wcnt}, 32'd1);
    stop_run();

    // Reset pulse in the middle of an acknowledge
    start_run(8'd40, 8'd10, 1'b0, 8'd0);
    expect_store(8'd40, 16'h6000);
    @(negedge aclk);
    bus.din   = 16'h6000;
    bus.write = 1'b1;
    wait_ack(got);
    chk("t6_ack", {31'd0, got}, 32'd1);
    #2;
    aresetn = 1'b0;
    #1;
    chk_all_zero("t6_rst");
    START_REG = 1'b0;
    bus.write = 1'b0;
    @(negedge aclk);
    aresetn = 1'b1;
    repeat (10) @(negedge aclk);
    chk("t6_busy", {31'd0, busy}, 32'd0);
    chk("t6_wcnt", {24'd0, wcnt}, 32'd0);

    chk("sb_empty", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
